// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Holds the FSM state encoding and the rotating priority scan.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Scan last+1, last+2, ... (mod 4); return {found, idx}
  function automatic logic [IDX_W:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] idx;
    r = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!r[IDX_W] && req[idx]) begin
        r = {1'b1, idx};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable.
// Used for the grant output and for the owner mask.
module dec2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] y
);

  // One-hot select, all zero when disabled
  always_comb begin
    y = 4'b0000;
    if (en) begin
      y = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a hold limit.
// Grant, index, valid and switch are all driven from registers.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       switch
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic HOLD_ON = (MAX_HOLD != 0);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             switch_q, switch_d;

  logic [3:0] own_mask;
  logic [3:0] others;
  logic       any_other;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       leave;

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = idx_q;
  assign switch    = switch_q;

  dec2to4 u_gnt (
    .idx (idx_q),
    .en  (gnt_valid),
    .y   (gnt)
  );

  // Owner bit, removed from the scan so preemption never re-picks it
  dec2to4 u_mask (
    .idx (idx_q),
    .en  (1'b1),
    .y   (own_mask)
  );

  assign others    = req & ~own_mask;
  assign any_other = |others;
  assign pick_idle = rr_pick(req, last_q);
  assign pick_next = rr_pick(others, idx_q);

  // Release wins over preemption; both hand off the same way
  assign leave = !req[idx_q] ||
                 (HOLD_ON && hold_q == HOLD_LAST && any_other);

  // Next-state: pick winner, hand off, or keep and count
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    hold_d   = hold_q;
    switch_d = 1'b0;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_idle[2]) begin
            state_d  = ST_GRANT;
            idx_d    = pick_idle[1:0];
            last_d   = pick_idle[1:0];
            hold_d   = '0;
            switch_d = 1'b1;
          end
        end
        ST_GRANT: begin
          if (leave) begin
            hold_d = '0;
            if (pick_next[2]) begin
              idx_d    = pick_next[1:0];
              last_d   = pick_next[1:0];
              switch_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (!any_other || !HOLD_ON) begin
            hold_d = '0;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset restarts priority at requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      last_q   <= 2'd3;
      hold_q   <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      switch_q <= switch_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with a queue-based scoreboard.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       switch;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  gnt;
    logic        sw;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  rr_arbiter4 #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .switch    (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Drive one cycle and queue what must appear after the next edge
  task automatic step(input logic r, input logic e,
                      input logic [3:0] rq,
                      input logic [3:0] eg, input logic es);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    step_no++;
    x.tag = 16'(step_no);
    x.gnt = eg;
    x.sw  = es;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every cycle an expectation is pending
  initial begin
    exp_t x;
    logic ev;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        ev  = (x.gnt != 4'b0000);
        bad = (gnt !== x.gnt) || (gnt_valid !== ev) ||
              (switch !== x.sw) ||
              (ev && gnt_idx !== oh2idx(x.gnt));
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL step%0d: gnt=%b idx=%0d valid=%b switch=%b, expected gnt=%b idx=%0d valid=%b switch=%b",
                   x.tag, gnt, gnt_idx, gnt_valid, switch,
                   x.gnt, oh2idx(x.gnt), ev, x.sw);
        end
      end
    end
  end

  initial begin
    logic [3:0] oh;
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b0000;

    // Reset and idle
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // All requesting: 8 cycles each, rotating 0,1,2,3,0
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      for (int c = 0; c < 8; c++)
        step(1'b0, 1'b1, 4'b1111, oh, (c == 0));
    end

    // Clean restart, then lone requester 2 is never preempted
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 20; c++)
      step(1'b0, 1'b1, 4'b0100, 4'b0100, (c == 0));
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // Owner 1 releases while 0 and 3 arrive: RR goes to 3
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // en=0 freezes grant through a release
    step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1);
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // en=0 blocks a new grant from idle
    step(1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1);

    // Back-to-back handoff to 3, then reset mid-grant
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1);
    step(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b0);
    step(1'b1, 1'b1, 4'b1001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1);

    // Reset wins even with en=0; priority restarts at 0
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1);
    step(1'b1, 1'b0, 4'b1001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
